// File: rtl/cabin_motion_ctrl.sv
// rtl/cabin_motion_ctrl.sv - elevator cabin motion and door sequencer
// Optional overload door hold and departure block: define OVERLOAD_HOLD_EN.
module cabin_motion_ctrl #(
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [1:0] alvo,
  input  logic       cheio,
  output logic [1:0] andar,
  output logic       subindo,
  output logic       descendo,
  output logic       porta_aberta,
  output logic       chegada,
  output logic       ocupado
);

  localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    PORTA    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      andar_nxt;
  logic [1:0]      alvo_lat, alvo_lat_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   dcnt, dcnt_nxt;
  logic            chegada_nxt;
  logic            hold;

`ifdef OVERLOAD_HOLD_EN
  assign hold = cheio;
`else
  logic unused_cheio;
  assign unused_cheio = cheio;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state        <= PARADO;
      andar        <= 2'b00;
      alvo_lat     <= 2'b00;
      cnt          <= '0;
      dcnt         <= '0;
      subindo      <= 1'b0;
      descendo     <= 1'b0;
      porta_aberta <= 1'b0;
      chegada      <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      state        <= state_nxt;
      andar        <= andar_nxt;
      alvo_lat     <= alvo_lat_nxt;
      cnt          <= cnt_nxt;
      dcnt         <= dcnt_nxt;
      subindo      <= (state_nxt == SUBINDO);
      descendo     <= (state_nxt == DESCENDO);
      porta_aberta <= (state_nxt == PORTA);
      chegada      <= chegada_nxt;
      ocupado      <= (state_nxt != PARADO);
    end
  end

  always_comb begin
    state_nxt    = state;
    andar_nxt    = andar;
    alvo_lat_nxt = alvo_lat;
    cnt_nxt      = cnt;
    dcnt_nxt     = dcnt;
    chegada_nxt  = 1'b0;
    case (state)
      PARADO: begin
        // Target is latched only here; changes while moving are ignored.
        if (!hold && alvo != 2'b11 && alvo != andar) begin
          alvo_lat_nxt = alvo;
          cnt_nxt      = TRAVEL_LOAD;
          state_nxt    = (alvo > andar) ? SUBINDO : DESCENDO;
        end
      end
      SUBINDO, DESCENDO: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          andar_nxt = (state == SUBINDO) ? andar + 2'd1 : andar - 2'd1;
          if (andar_nxt == alvo_lat) begin
            state_nxt   = PORTA;
            dcnt_nxt    = DOOR_LOAD;
            chegada_nxt = 1'b1;
          end else begin
            cnt_nxt = TRAVEL_LOAD;
          end
        end
      end
      PORTA: begin
        if (dcnt != '0) begin
          dcnt_nxt = dcnt - 1'b1;
        end else if (hold) begin
          dcnt_nxt = DOOR_LOAD;
        end else begin
          state_nxt = PARADO;
        end
      end
      default: state_nxt = PARADO;
    endcase
  end

endmodule

// File: tb/tb_cabin_motion_ctrl.sv
// tb/tb_cabin_motion_ctrl.sv - scoreboard bench for cabin_motion_ctrl
// Expected results branch on OVERLOAD_HOLD_EN to match the build.
module tb_cabin_motion_ctrl;

  logic       clk;
  logic       nreset;
  logic [1:0] alvo;
  logic       cheio;
  logic [1:0] andar;
  logic       subindo, descendo, porta_aberta, chegada, ocupado;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  typedef struct {
    logic [6:0] v;
    int         id;
  } exp_t;

  exp_t q[$];

  // flags: {subindo, descendo, porta_aberta, chegada, ocupado}
  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] UP   = 5'b10001;
  localparam logic [4:0] DN   = 5'b01001;
  localparam logic [4:0] ARR  = 5'b00111;
  localparam logic [4:0] DOOR = 5'b00101;

  cabin_motion_ctrl #(.TRAVEL_TICKS(3), .DOOR_TICKS(4)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .alvo         (alvo),
    .cheio        (cheio),
    .andar        (andar),
    .subindo      (subindo),
    .descendo     (descendo),
    .porta_aberta (porta_aberta),
    .chegada      (chegada),
    .ocupado      (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {andar, subindo, descendo, porta_aberta, chegada, ocupado};
  endfunction

  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // One clock of stimulus; the expectation is checked by the monitor.
  task automatic cyc(input logic [1:0] a, input logic ch, input logic [1:0] ea, input logic [4:0] ef);
    exp_t e;
    alvo  = a;
    cheio = ch;
    e.v   = {ea, ef};
    e.id  = step;
    q.push_back(e);
    step++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp($sformatf("step%0d", e.id), outs(), e.v);
    end
  end

  initial begin
    alvo   = 2'b00;
    cheio  = 1'b0;
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    cmp("reset_state", outs(), 7'b0);
    nreset = 1'b0;

    // idle at floor 1
    repeat (10) cyc(2'b00, 1'b0, 2'd0, IDLE);

    // floor 1 -> floor 3
    repeat (3) cyc(2'b10, 1'b0, 2'd0, UP);
    repeat (3) cyc(2'b10, 1'b0, 2'd1, UP);
    cyc(2'b10, 1'b0, 2'd2, ARR);
    repeat (3) cyc(2'b10, 1'b0, 2'd2, DOOR);
    repeat (2) cyc(2'b10, 1'b0, 2'd2, IDLE);

    // floor 3 -> floor 1, target change mid-travel ignored, then up to floor 2
    cyc(2'b00, 1'b0, 2'd2, DN);
    repeat (2) cyc(2'b01, 1'b0, 2'd2, DN);
    repeat (3) cyc(2'b01, 1'b0, 2'd1, DN);
    cyc(2'b01, 1'b0, 2'd0, ARR);
    repeat (3) cyc(2'b01, 1'b0, 2'd0, DOOR);
    cyc(2'b01, 1'b0, 2'd0, IDLE);
    repeat (3) cyc(2'b01, 1'b0, 2'd0, UP);
    cyc(2'b01, 1'b0, 2'd1, ARR);
    repeat (3) cyc(2'b01, 1'b0, 2'd1, DOOR);
    cyc(2'b01, 1'b0, 2'd1, IDLE);

    // invalid target code
    repeat (5) cyc(2'b11, 1'b0, 2'd1, IDLE);

    // asynchronous reset while moving
    repeat (2) cyc(2'b00, 1'b0, 2'd1, DN);
    #2 nreset = 1'b1;
    #1 cmp("async_reset", outs(), 7'b0);
    @(negedge clk);
    cmp("reset_held", outs(), 7'b0);
    nreset = 1'b0;
    repeat (3) cyc(2'b00, 1'b0, 2'd0, IDLE);

    // overload during door cycle
    cyc(2'b01, 1'b0, 2'd0, UP);
    repeat (2) cyc(2'b01, 1'b1, 2'd0, UP);
    cyc(2'b01, 1'b1, 2'd1, ARR);
    repeat (3) cyc(2'b01, 1'b1, 2'd1, DOOR);
`ifdef OVERLOAD_HOLD_EN
    repeat (5) cyc(2'b01, 1'b1, 2'd1, DOOR);
    repeat (3) cyc(2'b01, 1'b0, 2'd1, DOOR);
    cyc(2'b01, 1'b0, 2'd1, IDLE);
    // departure blocked while overloaded
    repeat (3) cyc(2'b10, 1'b1, 2'd1, IDLE);
    cyc(2'b10, 1'b0, 2'd1, UP);
`else
    repeat (5) cyc(2'b01, 1'b1, 2'd1, IDLE);
    repeat (3) cyc(2'b01, 1'b0, 2'd1, IDLE);
    cyc(2'b01, 1'b0, 2'd1, IDLE);
    // cheio has no effect on departure
    repeat (3) cyc(2'b10, 1'b1, 2'd1, UP);
    cyc(2'b10, 1'b1, 2'd2, ARR);
`endif

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
